// File: rtl/pkt_buffer_writer.sv
// pkt_buffer_writer: ingress stage ahead of data_mover.
// Pops a free pktID, writes accepted flits to the packet buffer at {pktID, flit_idx}
// and emits one metadata_t word per finished packet.
// Optional build macro PKT_BUF_WRITER_STATS_EN adds stat_pkt / stat_overflow / stat_nosop counters.
//
// state    | meaning
// SOP_WAIT | between packets; sop-less flits are dropped
// BODY     | inside a packet, flits stored at flit_cnt
// DISCARD  | packet exceeded MAX_FLITS; drop flits until eop

package pkt_buffer_writer_pkg;
  localparam int PKT_AWIDTH    = 9;
  localparam int PKTBUF_AWIDTH = PKT_AWIDTH + 5;
  localparam int MAX_FLITS     = 31;
  localparam logic [3:0] PKT_DROP = 4'b1000;

  typedef struct packed {
    logic [3:0]            pkt_flags;
    logic [PKT_AWIDTH-1:0] pkt_id;
    logic [4:0]            flits;
    logic [7:0]            hdr_len;
    logic [15:0]           len;
    logic [103:0]          tuple;
  } metadata_t;

  typedef struct packed {
    logic [511:0] data;
    logic         sop;
    logic         eop;
    logic [5:0]   empty;
  } flit_t;
endpackage

module pkt_buffer_writer
  import pkt_buffer_writer_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_pkt_sop,
  input  logic                     in_pkt_eop,
  input  logic                     in_pkt_valid,
  input  logic [511:0]             in_pkt_data,
  input  logic [5:0]               in_pkt_empty,
  output logic                     in_pkt_ready,
  input  logic                     in_meta_valid,
  input  metadata_t                in_meta_data,
  output logic                     in_meta_ready,
  input  logic                     emptylist_out_valid,
  input  logic [PKT_AWIDTH-1:0]    emptylist_out_data,
  output logic                     emptylist_out_ready,
  output logic [PKTBUF_AWIDTH-1:0] pkt_buffer_address,
  output logic                     pkt_buffer_write,
  output flit_t                    pkt_buffer_writedata,
  output logic                     meta_valid,
  output metadata_t                meta_data,
  input  logic                     meta_ready
`ifdef PKT_BUF_WRITER_STATS_EN
  ,
  output logic [31:0]              stat_pkt,
  output logic [31:0]              stat_overflow,
  output logic [31:0]              stat_nosop
`endif
);

  typedef enum logic [1:0] {SOP_WAIT, BODY, DISCARD} state_t;

  localparam logic [4:0] MAX_IDX = MAX_FLITS[4:0];

  state_t                state;
  logic                  id_valid;
  logic [PKT_AWIDTH-1:0] cur_id;
  logic [4:0]            flit_cnt;

  logic       meta_stall;
  logic       flit_acc;
  logic       id_pop;
  logic       sop_start;
  logic       finish;
  logic       writable;
  logic       fin_over;
  logic       nosop_drop;
  logic [4:0] wr_idx;
  logic [4:0] next_cnt;

  // Handshake decode; everything the outside sees combinationally is forced low in reset.
  always_comb begin
    meta_stall          = meta_valid & ~meta_ready;
    in_pkt_ready        = rst_n & id_valid & in_meta_valid & ~meta_stall;
    emptylist_out_ready = rst_n & ~id_valid;
    flit_acc            = in_pkt_valid & in_pkt_ready;
    id_pop              = emptylist_out_valid & emptylist_out_ready;
    sop_start           = flit_acc & (state == SOP_WAIT) & in_pkt_sop;
    nosop_drop          = flit_acc & (state == SOP_WAIT) & ~in_pkt_sop;
    finish              = flit_acc & in_pkt_eop & ((state != SOP_WAIT) | in_pkt_sop);
    in_meta_ready       = finish;
    // a flit arriving with all 31 slots used is the overflowing one and is never stored
    writable            = sop_start | (flit_acc & (state == BODY) & (flit_cnt != MAX_IDX));
    fin_over            = (state == DISCARD) | ((state == BODY) & (flit_cnt == MAX_IDX));
    wr_idx              = sop_start ? 5'd0 : flit_cnt;
    next_cnt            = wr_idx + {4'd0, writable};
  end

  // Packet FSM, ID prefetch, buffer write port and metadata output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                <= SOP_WAIT;
      id_valid             <= 1'b0;
      cur_id               <= '0;
      flit_cnt             <= '0;
      pkt_buffer_write     <= 1'b0;
      pkt_buffer_address   <= '0;
      pkt_buffer_writedata <= '0;
      meta_valid           <= 1'b0;
      meta_data            <= '0;
`ifdef PKT_BUF_WRITER_STATS_EN
      stat_pkt             <= '0;
      stat_overflow        <= '0;
      stat_nosop           <= '0;
`endif
    end else begin
      pkt_buffer_write <= writable;
      if (writable) begin
        pkt_buffer_address   <= {cur_id, wr_idx};
        pkt_buffer_writedata <= {in_pkt_data, in_pkt_sop, in_pkt_eop, in_pkt_empty};
        flit_cnt             <= next_cnt;
      end

      if (id_pop) begin
        id_valid <= 1'b1;
        cur_id   <= emptylist_out_data;
      end else if (finish) begin
        id_valid <= 1'b0;
      end

      if (finish) begin
        state <= SOP_WAIT;
      end else if (sop_start) begin
        state <= BODY;
      end else if (flit_acc && (state == BODY) && !writable) begin
        state <= DISCARD;
      end

      // a new word may replace the old one in the very cycle the old one is taken
      if (finish) begin
        meta_valid          <= 1'b1;
        meta_data           <= in_meta_data;
        meta_data.pkt_id    <= cur_id;
        meta_data.flits     <= next_cnt;
        meta_data.pkt_flags <= fin_over ? PKT_DROP : in_meta_data.pkt_flags;
      end else if (meta_valid && meta_ready) begin
        meta_valid <= 1'b0;
      end

`ifdef PKT_BUF_WRITER_STATS_EN
      if (finish)              stat_pkt      <= stat_pkt + 32'd1;
      if (finish && fin_over)  stat_overflow <= stat_overflow + 32'd1;
      if (nosop_drop)          stat_nosop    <= stat_nosop + 32'd1;
`endif
    end
  end

endmodule

// File: tb/tb_pkt_buffer_writer.sv
// Bench for pkt_buffer_writer: directed scenarios plus randomized traffic, checked
// against a packet-level reference model kept below.
module tb_pkt_buffer_writer;
  import pkt_buffer_writer_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     in_pkt_sop, in_pkt_eop, in_pkt_valid;
  logic [511:0]             in_pkt_data;
  logic [5:0]               in_pkt_empty;
  logic                     in_pkt_ready;
  logic                     in_meta_valid;
  metadata_t                in_meta_data;
  logic                     in_meta_ready;
  logic                     emptylist_out_valid;
  logic [PKT_AWIDTH-1:0]    emptylist_out_data;
  logic                     emptylist_out_ready;
  logic [PKTBUF_AWIDTH-1:0] pkt_buffer_address;
  logic                     pkt_buffer_write;
  flit_t                    pkt_buffer_writedata;
  logic                     meta_valid;
  metadata_t                meta_data;
  logic                     meta_ready;
`ifdef PKT_BUF_WRITER_STATS_EN
  logic [31:0] stat_pkt, stat_overflow, stat_nosop;
`endif

  always #5 clk = ~clk;

  pkt_buffer_writer dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .in_pkt_sop           (in_pkt_sop),
    .in_pkt_eop           (in_pkt_eop),
    .in_pkt_valid         (in_pkt_valid),
    .in_pkt_data          (in_pkt_data),
    .in_pkt_empty         (in_pkt_empty),
    .in_pkt_ready         (in_pkt_ready),
    .in_meta_valid        (in_meta_valid),
    .in_meta_data         (in_meta_data),
    .in_meta_ready        (in_meta_ready),
    .emptylist_out_valid  (emptylist_out_valid),
    .emptylist_out_data   (emptylist_out_data),
    .emptylist_out_ready  (emptylist_out_ready),
    .pkt_buffer_address   (pkt_buffer_address),
    .pkt_buffer_write     (pkt_buffer_write),
    .pkt_buffer_writedata (pkt_buffer_writedata),
    .meta_valid           (meta_valid),
    .meta_data            (meta_data),
    .meta_ready           (meta_ready)
`ifdef PKT_BUF_WRITER_STATS_EN
    ,
    .stat_pkt             (stat_pkt),
    .stat_overflow        (stat_overflow),
    .stat_nosop           (stat_nosop)
`endif
  );

  typedef struct {
    logic [511:0] data;
    logic         sop;
    logic         eop;
    logic [5:0]   empty;
    metadata_t    meta;
  } tb_flit_t;

  tb_flit_t              fq[$];
  logic [PKT_AWIDTH-1:0] popped[$];
  metadata_t             exp_meta[$];

  int n_tests = 0;
  int n_fail  = 0;

  // stimulus knobs (percent)
  int p_valid = 100, p_el = 100, p_mready = 100, p_mvalid = 100;
  bit force_el_off = 0, force_mr_off = 0;
  bit rst_req = 0;
  logic [PKT_AWIDTH-1:0] id_next;

  // reference model state
  bit                       m_in_pkt = 0;
  int                       m_cnt    = 0;
  logic [PKT_AWIDTH-1:0]    m_id     = '0;
  bit                       m_pend   = 0;
  bit                       wr_exp   = 0;
  bit                       rst_seen = 1;
  logic [PKTBUF_AWIDTH-1:0] wr_addr_exp;
  flit_t                    wr_data_exp;
  int n_fin = 0, n_over = 0, n_nosop = 0;

  task automatic check_val(input string tag, input logic [1023:0] act, input logic [1023:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic metadata_t rand_meta();
    metadata_t m;
    m.pkt_flags = 4'($urandom_range(0, 7));
    m.pkt_id    = PKT_AWIDTH'($urandom);
    m.flits     = 5'($urandom);
    m.hdr_len   = 8'($urandom);
    m.len       = 16'($urandom);
    m.tuple     = 104'({$urandom, $urandom, $urandom, $urandom});
    return m;
  endfunction

  task automatic gen_pkt(input int len);
    metadata_t m = rand_meta();
    for (int i = 0; i < len; i++) begin
      tb_flit_t f;
      f.data  = {16{$urandom}};
      f.sop   = (i == 0);
      f.eop   = (i == len - 1);
      f.empty = f.eop ? 6'($urandom) : 6'd0;
      f.meta  = m;
      fq.push_back(f);
    end
  endtask

  task automatic gen_junk();
    tb_flit_t f;
    f.data  = {16{$urandom}};
    f.sop   = 1'b0;
    f.eop   = 1'b0;
    f.empty = 6'd0;
    f.meta  = rand_meta();
    fq.push_back(f);
  endtask

  // One clock: check registered outputs, drive new inputs, then check combinational
  // outputs and advance the model for the edge that follows.
  task automatic cycle();
    bit held, exp_rdy, fin;
    tb_flit_t f;
    metadata_t em;
    @(negedge clk);
    check_val("wr_strobe", pkt_buffer_write, wr_exp);
    if (wr_exp && pkt_buffer_write) begin
      check_val("wr_addr", pkt_buffer_address, wr_addr_exp);
      check_val("wr_data", pkt_buffer_writedata, wr_data_exp);
    end
    if (rst_seen) begin
      check_val("rst_addr", pkt_buffer_address, 0);
      check_val("rst_wdata", pkt_buffer_writedata, 0);
      check_val("rst_meta_data", meta_data, 0);
    end
    check_val("meta_valid", meta_valid, m_pend);
    if (m_pend && meta_valid && exp_meta.size() > 0)
      check_val("meta_data", meta_data, exp_meta[0]);

    rst_n = rst_req;
    in_pkt_valid = (fq.size() > 0) && ($urandom_range(0, 99) < p_valid);
    if (fq.size() > 0) begin
      in_pkt_data  = fq[0].data;
      in_pkt_sop   = fq[0].sop;
      in_pkt_eop   = fq[0].eop;
      in_pkt_empty = fq[0].empty;
      in_meta_data = fq[0].meta;
    end
    in_meta_valid       = ($urandom_range(0, 99) < p_mvalid);
    emptylist_out_valid = !force_el_off && ($urandom_range(0, 99) < p_el);
    emptylist_out_data  = id_next;
    meta_ready          = !force_mr_off && ($urandom_range(0, 99) < p_mready);
    #1;

    held    = (popped.size() > 0) || m_in_pkt;
    exp_rdy = rst_n && held && in_meta_valid && !(m_pend && !meta_ready);
    check_val("el_ready", emptylist_out_ready, rst_n && !held);
    check_val("in_pkt_ready", in_pkt_ready, exp_rdy);
    wr_exp = 0;
    fin    = 0;
    if (!rst_n) begin
      popped.delete();
      exp_meta.delete();
      m_in_pkt = 0;
      m_pend   = 0;
      rst_seen = 1;
      n_fin = 0; n_over = 0; n_nosop = 0;
    end else begin
      rst_seen = 0;
      if (m_pend && meta_ready) begin
        m_pend = 0;
        void'(exp_meta.pop_front());
      end
      if (emptylist_out_valid && emptylist_out_ready) begin
        popped.push_back(id_next);
        id_next = PKT_AWIDTH'($urandom);
      end
      if (in_pkt_valid && in_pkt_ready && fq.size() > 0) begin
        f = fq.pop_front();
        if (!m_in_pkt && !f.sop) begin
          n_nosop++;
        end else begin
          if (!m_in_pkt) begin
            m_id     = (popped.size() > 0) ? popped.pop_front() : '0;
            m_in_pkt = 1;
            m_cnt    = 0;
          end
          if (m_cnt < MAX_FLITS) begin
            wr_exp      = 1;
            wr_addr_exp = {m_id, 5'(m_cnt)};
            wr_data_exp = {f.data, f.sop, f.eop, f.empty};
          end
          m_cnt++;
          if (f.eop) begin
            fin          = 1;
            em           = f.meta;
            em.pkt_id    = m_id;
            em.flits     = 5'((m_cnt > MAX_FLITS) ? MAX_FLITS : m_cnt);
            em.pkt_flags = (m_cnt > MAX_FLITS) ? PKT_DROP : f.meta.pkt_flags;
            exp_meta.push_back(em);
            m_pend   = 1;
            m_in_pkt = 0;
            n_fin++;
            if (m_cnt > MAX_FLITS) n_over++;
          end
        end
      end
    end
    check_val("in_meta_ready", in_meta_ready, fin);
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_until_idle(input int budget);
    int c = 0;
    while ((fq.size() > 0 || m_pend) && c < budget) begin
      cycle();
      c++;
    end
    if (c >= budget) check_val("drain_timeout", c, 0);
    cycle();
  endtask

  initial begin
    int c;
    rst_n = 0; in_pkt_valid = 0; in_pkt_sop = 0; in_pkt_eop = 0;
    in_pkt_data = '0; in_pkt_empty = '0; in_meta_valid = 0; in_meta_data = '0;
    emptylist_out_valid = 0; emptylist_out_data = '0; meta_ready = 0;
    id_next = '0;
    repeat (2) @(posedge clk);
    run_cycles(3);
    rst_req = 1;

    // single flit packet on ID 7 -> address 224
    id_next = PKT_AWIDTH'(7);
    gen_pkt(1);
    run_until_idle(100);

    // 5-flit packet on ID 3 -> addresses 96..100
    id_next = PKT_AWIDTH'(3);
    gen_pkt(5);
    run_until_idle(100);

    // 40-flit packet on ID 2: 31 stored, rest dropped, flagged PKT_DROP
    id_next = PKT_AWIDTH'(2);
    gen_pkt(40);
    run_until_idle(200);

    // boundary lengths
    gen_pkt(31);
    gen_pkt(33);
    run_until_idle(300);

    // back-to-back 2-flit packets with data_mover stalled for 10 cycles
    force_mr_off = 1;
    gen_pkt(2);
    gen_pkt(2);
    run_cycles(10);
    force_mr_off = 0;
    run_until_idle(100);

    // emptylist dry for 20 cycles with traffic pending
    force_el_off = 1;
    gen_pkt(3);
    gen_pkt(2);
    gen_pkt(4);
    run_cycles(20);
    force_el_off = 0;
    run_until_idle(200);

    // randomized traffic
    p_valid = 70; p_el = 60; p_mready = 60; p_mvalid = 90;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 99) < 20) gen_junk();
      if ($urandom_range(0, 99) < 85) gen_pkt($urandom_range(1, 8));
      else begin
        case ($urandom_range(0, 3))
          0: gen_pkt(30);
          1: gen_pkt(31);
          2: gen_pkt(33);
          default: gen_pkt(40);
        endcase
      end
    end
    run_until_idle(20000);

    // reset in the middle of a 4-flit packet
    p_valid = 100; p_el = 100; p_mready = 100; p_mvalid = 100;
    gen_pkt(4);
    c = 0;
    while (!(m_in_pkt && m_cnt == 2) && c < 100) begin
      cycle();
      c++;
    end
    check_val("midpkt_reach", c < 100, 1);
    rst_req = 0;
    cycle();
    fq.delete();
    rst_req = 1;
    gen_junk();
    gen_pkt(3);
    run_until_idle(100);

`ifdef PKT_BUF_WRITER_STATS_EN
    check_val("stat_pkt", stat_pkt, n_fin);
    check_val("stat_overflow", stat_overflow, n_over);
    check_val("stat_nosop", stat_nosop, n_nosop);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
